// File: rtl/dmux_1x2_16bits_buf.sv
// dmux_1x2_16bits_buf
//   Routes 16-bit words from a single input port into one of two buffered
//   output branches (A or B). Each branch is a DEPTH-entry FIFO with a
//   registered write (one-cycle latency, no bypass) and a head word that is
//   presented combinationally from the storage array.
//
// Ports (top):
//   clk_in       : single clock, rising-edge state updates
//   rst_n_in     : synchronous active-low reset
//   data_in      : word to route
//   sel_in       : destination, 0 = branch A, 1 = branch B
//   valid_in     : data_in/sel_in valid
//   ready_out    : block accepts the word this cycle
//   a/b_data_out : head word of the branch buffer (16'h0000 when empty)
//   a/b_valid_out: branch buffer non-empty
//   a/b_ready_in : downstream consumes the head word
//   a/b_level_out: branch occupancy, 0..DEPTH
//
// Handshake: every channel uses valid/ready. A transfer happens on a rising
// edge where valid and ready are both high. valid never depends on ready;
// ready_out depends only on sel_in, the selected branch's fill state and its
// ready_in, never on valid_in.

// One branch buffer: circular storage with read/write pointers and a level
// counter. Pointers wrap naturally because DEPTH is a power of two.
module dmux_branch_fifo #(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [15:0]              push_data,
    input  logic                     ready_in,
    output logic [15:0]              data,
    output logic                     valid,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH) + 1;

    logic [15:0]   mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [LW-1:0] count;
    logic          pop;

    // A pop only happens when there is a head word; ready_in on an empty
    // branch is ignored.
    assign pop   = valid && ready_in;
    assign valid = (count != '0);
    assign full  = (count == LW'(DEPTH));
    assign level = count;
    assign data  = valid ? mem[rd_ptr] : 16'h0000;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            // Simultaneous push and pop leaves the level unchanged.
            case ({push, pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the head is masked to zero while empty, and
    // reset clears the level so stale entries are never exposed again.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem[wr_ptr] <= push_data;
        end
    end
endmodule

module dmux_1x2_16bits_buf #(
    parameter int DEPTH = 2
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    input  logic [15:0]             data_in,
    input  logic                    sel_in,
    input  logic                    valid_in,
    output logic                    ready_out,
    output logic [15:0]             a_data_out,
    output logic [15:0]             b_data_out,
    output logic                    a_valid_out,
    output logic                    b_valid_out,
    input  logic                    a_ready_in,
    input  logic                    b_ready_in,
    output logic [$clog2(DEPTH):0]  a_level_out,
    output logic [$clog2(DEPTH):0]  b_level_out
);
    logic a_full;
    logic b_full;
    logic a_room;
    logic b_room;
    logic accept;
    logic a_push;
    logic b_push;

    // A full branch can still take a word if its head leaves this cycle;
    // a full branch always has valid high, so ready_in alone implies a pop.
    assign a_room    = !a_full || a_ready_in;
    assign b_room    = !b_full || b_ready_in;
    assign ready_out = sel_in ? b_room : a_room;

    // Words offered while reset is asserted are dropped.
    assign accept = valid_in && ready_out && rst_n_in;
    assign a_push = accept && !sel_in;
    assign b_push = accept &&  sel_in;

    dmux_branch_fifo #(.DEPTH(DEPTH)) u_branch_a (
        .clk       (clk_in),
        .rst_n     (rst_n_in),
        .push      (a_push),
        .push_data (data_in),
        .ready_in  (a_ready_in),
        .data      (a_data_out),
        .valid     (a_valid_out),
        .full      (a_full),
        .level     (a_level_out)
    );

    dmux_branch_fifo #(.DEPTH(DEPTH)) u_branch_b (
        .clk       (clk_in),
        .rst_n     (rst_n_in),
        .push      (b_push),
        .push_data (data_in),
        .ready_in  (b_ready_in),
        .data      (b_data_out),
        .valid     (b_valid_out),
        .full      (b_full),
        .level     (b_level_out)
    );
endmodule

// File: tb/tb_dmux_1x2_16bits_buf.sv
// Self-checking bench for dmux_1x2_16bits_buf (DEPTH = 2): directed vectors
// followed by a randomized run checked against per-branch expected queues.
module tb_dmux_1x2_16bits_buf;
    localparam int DEPTH = 2;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk_in;
    logic          rst_n_in;
    logic [15:0]   data_in;
    logic          sel_in;
    logic          valid_in;
    logic          ready_out;
    logic [15:0]   a_data_out;
    logic [15:0]   b_data_out;
    logic          a_valid_out;
    logic          b_valid_out;
    logic          a_ready_in;
    logic          b_ready_in;
    logic [LW-1:0] a_level_out;
    logic [LW-1:0] b_level_out;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_a_q[$];
    logic [15:0] exp_b_q[$];

    dmux_1x2_16bits_buf #(.DEPTH(DEPTH)) dut (
        .clk_in      (clk_in),
        .rst_n_in    (rst_n_in),
        .data_in     (data_in),
        .sel_in      (sel_in),
        .valid_in    (valid_in),
        .ready_out   (ready_out),
        .a_data_out  (a_data_out),
        .b_data_out  (b_data_out),
        .a_valid_out (a_valid_out),
        .b_valid_out (b_valid_out),
        .a_ready_in  (a_ready_in),
        .b_ready_in  (b_ready_in),
        .a_level_out (a_level_out),
        .b_level_out (b_level_out)
    );

    // ---------------- clock ----------------
    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // ---------------- checker ----------------
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Advance past the next rising edge; inputs are then changed away from it.
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic drive(input logic v, input logic s, input logic [15:0] d,
                         input logic ar, input logic br);
        valid_in   = v;
        sel_in     = s;
        data_in    = d;
        a_ready_in = ar;
        b_ready_in = br;
        #1;
    endtask

    task automatic check_empty(input string tag);
        check_eq({tag, "_a_level"}, 32'(a_level_out), 32'd0);
        check_eq({tag, "_b_level"}, 32'(b_level_out), 32'd0);
        check_eq({tag, "_a_valid"}, 32'(a_valid_out), 32'd0);
        check_eq({tag, "_b_valid"}, 32'(b_valid_out), 32'd0);
        check_eq({tag, "_a_data"},  32'(a_data_out),  32'h0);
        check_eq({tag, "_b_data"},  32'(b_data_out),  32'h0);
    endtask

    logic [15:0] stream_w [4];
    logic        m_ready;
    logic [15:0] m_a_head;
    logic [15:0] m_b_head;

    initial begin
        stream_w[0] = 16'h1111;
        stream_w[1] = 16'h2222;
        stream_w[2] = 16'h3333;
        stream_w[3] = 16'h4444;

        // ---- reset, with a push offered during reset ----
        rst_n_in = 1'b0;
        drive(1'b1, 1'b0, 16'hDEAD, 1'b0, 1'b0);
        tick();
        tick();
        check_empty("rst");
        check_eq("rst_ready_sel0", 32'(ready_out), 32'd1);
        drive(1'b1, 1'b1, 16'hBEEF, 1'b0, 1'b0);
        check_eq("rst_ready_sel1", 32'(ready_out), 32'd1);
        tick();
        rst_n_in = 1'b1;
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        check_empty("rst_discard");

        // ---- single push to A ----
        drive(1'b1, 1'b0, 16'h1234, 1'b0, 1'b0);
        check_eq("a1_ready", 32'(ready_out), 32'd1);
        tick();
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        check_eq("a1_valid", 32'(a_valid_out), 32'd1);
        check_eq("a1_data",  32'(a_data_out),  32'h1234);
        check_eq("a1_level", 32'(a_level_out), 32'd1);
        check_eq("a1_bvalid", 32'(b_valid_out), 32'd0);
        check_eq("a1_bdata", 32'(b_data_out), 32'h0);

        // ---- fill B while stalled ----
        drive(1'b1, 1'b1, 16'hAAAA, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b1, 16'hBBBB, 1'b0, 1'b0);
        check_eq("bfill_ready1", 32'(ready_out), 32'd1);
        tick();
        drive(1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
        check_eq("bfull_level", 32'(b_level_out), 32'd2);
        check_eq("bfull_ready_sel1", 32'(ready_out), 32'd0);
        check_eq("bfull_head", 32'(b_data_out), 32'hAAAA);
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        check_eq("bfull_ready_sel0", 32'(ready_out), 32'd1);

        // ---- push into full B with simultaneous pop ----
        drive(1'b1, 1'b1, 16'hCCCC, 1'b0, 1'b1);
        check_eq("bpp_ready", 32'(ready_out), 32'd1);
        tick();
        drive(1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
        check_eq("bpp_level", 32'(b_level_out), 32'd2);
        check_eq("bpp_head0", 32'(b_data_out), 32'hBBBB);
        drive(1'b0, 1'b1, 16'h0000, 1'b0, 1'b1);
        tick();
        check_eq("bpp_head1", 32'(b_data_out), 32'hCCCC);
        check_eq("bpp_level1", 32'(b_level_out), 32'd1);
        tick();
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        check_eq("bdrain_valid", 32'(b_valid_out), 32'd0);
        check_eq("bdrain_data", 32'(b_data_out), 32'h0);
        check_eq("bdrain_level", 32'(b_level_out), 32'd0);
        check_eq("a_hold_head", 32'(a_data_out), 32'h1234);

        // ---- A full and stalled, B streams ----
        drive(1'b1, 1'b0, 16'h5555, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        check_eq("afull_level", 32'(a_level_out), 32'd2);
        check_eq("afull_ready", 32'(ready_out), 32'd0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, stream_w[i], 1'b0, 1'b1);
            check_eq("stream_ready", 32'(ready_out), 32'd1);
            tick();
            check_eq("stream_bhead", 32'(b_data_out), 32'(stream_w[i]));
            check_eq("stream_blevel", 32'(b_level_out), 32'd1);
            check_eq("stream_ahead", 32'(a_data_out), 32'h1234);
            check_eq("stream_alevel", 32'(a_level_out), 32'd2);
        end
        drive(1'b0, 1'b1, 16'h0000, 1'b1, 1'b1);
        tick();
        check_eq("pop_a_head", 32'(a_data_out), 32'h5555);
        check_eq("pop_b_valid", 32'(b_valid_out), 32'd0);

        // ---- reset mid-operation ----
        rst_n_in = 1'b0;
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        tick();
        rst_n_in = 1'b1;
        drive(1'b1, 1'b0, 16'hA001, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b1, 16'hB001, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b1, 16'hB002, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        check_eq("pre_rst_alevel", 32'(a_level_out), 32'd1);
        check_eq("pre_rst_blevel", 32'(b_level_out), 32'd2);
        rst_n_in = 1'b0;
        drive(1'b1, 1'b0, 16'hDEAD, 1'b0, 1'b0);
        tick();
        rst_n_in = 1'b1;
        drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        check_empty("midrst");
        tick();
        tick();
        check_empty("midrst_later");

        // ---- randomized run against the expected queues ----
        rst_n_in = 1'b0;
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        tick();
        rst_n_in = 1'b1;
        exp_a_q.delete();
        exp_b_q.delete();
        for (int cyc = 0; cyc < 10000; cyc++) begin
            drive(($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)),
                  16'($urandom_range(0, 65535)),
                  ($urandom_range(0, 9) < 5), ($urandom_range(0, 9) < 5));
            m_ready = sel_in ? ((exp_b_q.size() < DEPTH) || b_ready_in)
                             : ((exp_a_q.size() < DEPTH) || a_ready_in);
            m_a_head = (exp_a_q.size() != 0) ? exp_a_q[0] : 16'h0000;
            m_b_head = (exp_b_q.size() != 0) ? exp_b_q[0] : 16'h0000;
            check_eq("rnd_ready",   32'(ready_out),   32'(m_ready));
            check_eq("rnd_a_valid", 32'(a_valid_out), 32'(exp_a_q.size() != 0));
            check_eq("rnd_b_valid", 32'(b_valid_out), 32'(exp_b_q.size() != 0));
            check_eq("rnd_a_data",  32'(a_data_out),  32'(m_a_head));
            check_eq("rnd_b_data",  32'(b_data_out),  32'(m_b_head));
            check_eq("rnd_a_level", 32'(a_level_out), 32'(exp_a_q.size()));
            check_eq("rnd_b_level", 32'(b_level_out), 32'(exp_b_q.size()));
            // Update the model for the coming edge: pops first, then the push.
            if (exp_a_q.size() != 0 && a_ready_in) void'(exp_a_q.pop_front());
            if (exp_b_q.size() != 0 && b_ready_in) void'(exp_b_q.pop_front());
            if (valid_in && m_ready) begin
                if (sel_in) exp_b_q.push_back(data_in);
                else        exp_a_q.push_back(data_in);
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dmux_1x2_16bits_buf.md
DMUX_1X2_16BITS_BUF -- requirements
Module: dmux_1x2_16bits_buf

Interface
REQ-001 SHALL have parameter DEPTH, default 2, per-branch buffer entries (power of two, 2..16).
REQ-002 SHALL have port clk_in, input, 1, single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n_in, input, 1, reset that is synchronous and active-low.
REQ-004 SHALL have port data_in, input, 16, word to route.
REQ-005 SHALL have port sel_in, input, 1, destination: 0 = branch A, 1 = branch B.
REQ-006 SHALL have port valid_in, input, 1, data_in/sel_in valid.
REQ-007 SHALL have port ready_out, output, 1, block accepts the word this cycle.
REQ-008 SHALL have ports a_data_out/b_data_out, output, 16 each, head word of each branch buffer.
REQ-009 SHALL have ports a_valid_out/b_valid_out, output, 1 each, branch buffer non-empty.
REQ-010 SHALL have ports a_ready_in/b_ready_in, input, 1 each, downstream consumes head.
REQ-011 SHALL have ports a_level_out/b_level_out, output, $clog2(DEPTH)+1 each, branch occupancy.

Function
REQ-012 SHALL accept (push) a word when valid_in && ready_out, into the buffer selected by sel_in.
REQ-013 SHALL drive ready_out = selected branch not full, OR selected branch full AND its ready_in high this cycle (pop frees a slot).
REQ-014 SHALL make ready_out depend combinationally on sel_in and x_ready_in only; never on valid_in.
REQ-015 SHALL pop branch X head when x_valid_out && x_ready_in; words with x_ready_in high while empty SHALL be ignored.
REQ-016 SHALL preserve FIFO order within each branch; branches are independent (A stall never blocks B pushes).
REQ-017 SHALL have latency 1: a word pushed at edge N appears on x_data_out with x_valid_out high after edge N (no same-cycle bypass).
REQ-018 SHALL hold x_data_out stable while x_valid_out high and x_ready_in low.
REQ-019 SHALL, on simultaneous push and pop of same branch, keep level unchanged and append new word behind remaining entries.
REQ-020 SHALL, on simultaneous push to one branch and pop of the other, update both levels independently.
REQ-021 SHALL wrap read/write pointers modulo DEPTH; level SHALL range 0..DEPTH exactly.
REQ-022 SHALL never push to a full branch without a same-cycle pop, and never pop an empty branch.
REQ-023 SHALL route data bits unmodified; bit i of data_in appears as bit i of x_data_out.
REQ-024 SHALL drive x_data_out = 16'h0000 when branch empty.

Reset
REQ-025 SHALL, when rst_n_in low at a rising edge, clear both buffers: levels 0, pointers 0, x_valid_out 0, x_data_out 16'h0000.
REQ-026 SHALL keep ready_out computed per REQ-013 during reset (branches empty, so 1); pushes during reset SHALL be discarded.
REQ-027 SHALL discard all buffered words when reset asserts mid-operation; no word stored before reset appears after.

Verification
REQ-028 Push 16'h1234 sel 0, a_ready_in 0 -> next cycle a_valid_out 1, a_data_out 16'h1234, a_level_out 1, b_valid_out 0.
REQ-029 DEPTH=2, push 16'hAAAA, 16'hBBBB to B with b_ready_in 0 -> b_level_out 2, ready_out 0 for sel 1, ready_out 1 for sel 0.
REQ-030 B full (AAAA, BBBB), b_ready_in 1, push 16'hCCCC sel 1 -> ready_out 1, level stays 2, B outputs BBBB then CCCC in order.
REQ-031 A full and stalled, stream 4 words sel 1 with b_ready_in 1 -> all accepted, B outputs them in order, A head unchanged.
REQ-032 Fill A with 1 word and B with 2, assert rst_n_in low one cycle -> all levels 0, valids 0, data outputs 16'h0000; old words never reappear.
REQ-033 Random valid_in/sel_in/ready_in for 10k cycles vs scoreboard per branch -> no loss, duplication or reordering; levels match model.
